transmissor_status: RTL and testbench

TRANSMISSOR_STATUS -- requirements
Module: transmissor_status

---
 rtl/smart_cargo_pkg.sv | 26 ++
 rtl/contador_m.sv | 30 +++
 rtl/transmissor_status.sv | 145 ++++++++++++++
 tb/tb_transmissor_status.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_cargo_pkg.sv
// Shared definitions for the elevator status link: FSM encoding, frame constants
// and the packing of the status byte.
package smart_cargo_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CAPTURA   = 4'd1,
    START     = 4'd2,
    DADOS     = 4'd3,
    STOP      = 4'd4,
    PROX_BYTE = 4'd5,
    FIM       = 4'd6
  } estado_t;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam int         FRAME_LEN = 3;

  function automatic logic [7:0] monta_status(input logic       eh_origem,
                                              input logic       tem_destino,
                                              input logic       sobe,
                                              input logic [1:0] prox,
                                              input logic [1:0] andar);
    return {1'b0, eh_origem, tem_destino, sobe, prox, andar};
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear; fim_o is high on the last count
// value so a caller can step once every M enabled cycles.
module contador_m #(
  parameter int M = 8,
  parameter int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock_i,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (zera_i) begin
      q_d = '0;
    end else if (conta_i) begin
      q_d = (q_q == N'(M - 1)) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    q_q <= q_d;
  end

  assign fim_o = (q_q == N'(M - 1));

endmodule

// File: rtl/transmissor_status.sv
// Sends a 3-byte 8N1 status frame (sync, status, xor check) whenever the floor or
// destination changes, on envia, or once after reset; TX is registered, 1-cycle gap between bytes.
module transmissor_status
  import smart_cargo_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] andar_atual,
  input  logic [1:0] prox_parada,
  input  logic       sobe,
  input  logic       tem_destino,
  input  logic       eh_origem,
  input  logic       envia,
  output logic       TX,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int DIV_RAW = CLOCK_FREQ / BAUD_RATE;
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;

  estado_t    estado_q, estado_d;
  logic       tx_q, tx_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] status_q, status_d;
  logic [1:0] ult_andar_q, ult_andar_d;
  logic [1:0] ult_prox_q, ult_prox_d;
  logic       pendente_q, pendente_d;

  logic       contando, zera_baud, fim_baud, mudou, gatilho;
  logic [7:0] byte_atual;

  assign contando  = estado_q inside {START, DADOS, STOP};
  assign zera_baud = !reset || !contando;

  contador_m #(.M(DIV)) u_baud (
    .clock_i (clock),
    .zera_i  (zera_baud),
    .conta_i (contando),
    .fim_o   (fim_baud)
  );

  assign mudou   = (andar_atual != ult_andar_q) || (prox_parada != ult_prox_q);
  assign gatilho = mudou || envia || pendente_q;

  always_comb begin
    case (byte_q)
      2'd0:    byte_atual = SYNC;
      2'd1:    byte_atual = status_q;
      default: byte_atual = SYNC ^ status_q;
    endcase
  end

  always_comb begin
    estado_d    = estado_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    status_d    = status_q;
    ult_andar_d = ult_andar_q;
    ult_prox_d  = ult_prox_q;
    pendente_d  = pendente_q;
    tx_d        = 1'b1;

    // Requests seen at CAPTURA are already part of the snapshot being taken.
    if (estado_q != OCIOSO && estado_q != CAPTURA && (mudou || envia)) begin
      pendente_d = 1'b1;
    end

    case (estado_q)
      OCIOSO: begin
        if (gatilho) estado_d = CAPTURA;
      end
      CAPTURA: begin
        status_d    = monta_status(eh_origem, tem_destino, sobe, prox_parada, andar_atual);
        ult_andar_d = andar_atual;
        ult_prox_d  = prox_parada;
        pendente_d  = 1'b0;
        byte_d      = 2'd0;
        bit_d       = 3'd0;
        estado_d    = START;
      end
      START: begin
        if (fim_baud) begin
          estado_d = DADOS;
          bit_d    = 3'd0;
        end
      end
      DADOS: begin
        if (fim_baud) begin
          if (bit_q == 3'd7) estado_d = STOP;
          else               bit_d    = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (fim_baud) estado_d = (byte_q == 2'(FRAME_LEN - 1)) ? FIM : PROX_BYTE;
      end
      PROX_BYTE: begin
        byte_d   = byte_q + 2'd1;
        estado_d = START;
      end
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase

    // TX follows the next state so the line level lines up with estado_q.
    case (estado_d)
      START:   tx_d = 1'b0;
      DADOS:   tx_d = byte_atual[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      tx_q        <= 1'b1;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      status_q    <= 8'h00;
      ult_andar_q <= 2'd0;
      ult_prox_q  <= 2'd0;
      pendente_q  <= 1'b1;
    end else begin
      estado_q    <= estado_d;
      tx_q        <= tx_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      status_q    <= status_d;
      ult_andar_q <= ult_andar_d;
      ult_prox_q  <= ult_prox_d;
      pendente_q  <= pendente_d;
    end
  end

  assign TX        = tx_q;
  assign ocupado   = (estado_q != OCIOSO);
  assign pronto    = (estado_q == FIM);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_transmissor_status.sv
// Bench for transmissor_status at DIV=8: expected bytes are queued by the stimulus,
// a UART-style receiver on the falling edge decodes TX and compares.
`timescale 1ns/1ps
module tb_transmissor_status;
  import smart_cargo_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] andar_atual = 2'd2;
  logic [1:0] prox_parada = 2'd1;
  logic       sobe = 1'b0, tem_destino = 1'b1, eh_origem = 1'b0, envia = 1'b0;
  logic       TX, ocupado, pronto;
  logic [3:0] db_estado;

  int         errors = 0, checks = 0;
  int         frames_exp = 0, frames_seen = 0;
  logic [7:0] exp_q[$];

  localparam int FRAME_CYCLES = 1 + 3 * 10 * 8 + 2 + 1;

  always #5 clock = ~clock;

  transmissor_status #(.CLOCK_FREQ(8), .BAUD_RATE(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .andar_atual (andar_atual),
    .prox_parada (prox_parada),
    .sobe        (sobe),
    .tem_destino (tem_destino),
    .eh_origem   (eh_origem),
    .envia       (envia),
    .TX          (TX),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  function automatic void chk(string nome, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nome, got, req, $time);
    end
  endfunction

  // Reference: a frame is the sync byte, the packed status and their xor.
  function automatic void push_frame();
    logic [7:0] b1;
    b1 = {1'b0, eh_origem, tem_destino, sobe, prox_parada, andar_atual};
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(8'hA5 ^ b1);
    frames_exp++;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_pronto(input string nome);
    int n;
    n = 0;
    while (n < 600) begin
      @(posedge clock);
      #1;
      n++;
      if (pronto) break;
    end
    if (!pronto) begin
      checks++;
      errors++;
      $display("FAIL %s: got no pronto required pronto within 600 cycles", nome);
    end
  endtask

  task automatic pulse_envia();
    envia = 1'b1;
    cycles(1);
    envia = 1'b0;
  endtask

  // Monitor: decodes TX bytes mid-bit and measures ocupado / pronto widths.
  initial begin
    int         rx_c, ocu_run, pr_run;
    logic       rx_busy;
    logic [7:0] rx_byte;
    rx_c = 0; ocu_run = 0; pr_run = 0; rx_busy = 1'b0; rx_byte = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rx_busy = 1'b0;
        ocu_run = 0;
        pr_run  = 0;
      end else begin
        if (ocupado) ocu_run++;
        else if (ocu_run != 0) begin
          chk("ocupado_len", ocu_run, FRAME_CYCLES);
          ocu_run = 0;
        end
        if (pronto) pr_run++;
        else if (pr_run != 0) begin
          chk("pronto_width", pr_run, 1);
          pr_run = 0;
          frames_seen++;
        end
        if (!rx_busy) begin
          if (TX == 1'b0) begin
            rx_busy = 1'b1;
            rx_c    = 0;
          end
        end else begin
          rx_c++;
          if (rx_c == 4) chk("start_bit", TX, 0);
          if (rx_c >= 12 && rx_c <= 68 && ((rx_c - 12) % 8) == 0)
            rx_byte[(rx_c - 12) / 8] = TX;
          if (rx_c == 76) begin
            chk("stop_bit", TX, 1);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL byte: got 0x%0h required no byte at %0t", rx_byte, $time);
            end else begin
              chk("byte", rx_byte, exp_q.pop_front());
            end
            rx_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int         n, m;
    logic [1:0] cap_andar;
    logic       do_envia, expect_frame;

    // Reset state and the frame forced by reset release.
    cycles(3);
    chk("rst_tx", TX, 1);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_estado", db_estado, 4'(OCIOSO));
    push_frame();
    reset = 1'b1;
    wait_pronto("reset_frame");
    cycles(3);
    chk("pronto_once", frames_seen, 1);

    // Idle floor change: latency to start bit and start bit length.
    andar_atual = 2'd3;
    push_frame();
    n = 0;
    while (n < 10) begin
      @(posedge clock);
      #1;
      n++;
      if (TX == 1'b0) break;
    end
    chk("tx_latency", n, 2);
    m = 0;
    while (TX == 1'b0 && m < 20) begin
      @(posedge clock);
      #1;
      m++;
    end
    chk("start_len", m, 8);
    wait_pronto("change_frame");
    cycles(3);

    // Three floor changes during one frame coalesce into one extra frame.
    prox_parada = prox_parada + 2'd1;
    cap_andar   = andar_atual;
    push_frame();
    cycles(30);
    andar_atual = 2'($urandom_range(0, 3));
    cycles(40);
    andar_atual = 2'($urandom_range(0, 3));
    cycles(40);
    andar_atual = cap_andar ^ 2'($urandom_range(1, 3));
    sobe        = 1'($urandom_range(0, 1));
    tem_destino = 1'($urandom_range(0, 1));
    eh_origem   = 1'($urandom_range(0, 1));
    push_frame();
    wait_pronto("burst_first");
    wait_pronto("burst_extra");
    cycles(30);
    chk("burst_single_extra", ocupado, 0);

    // envia alone resends; envia with a change gives one frame.
    push_frame();
    pulse_envia();
    wait_pronto("envia_resend");
    cycles(3);
    andar_atual = andar_atual + 2'd1;
    push_frame();
    pulse_envia();
    wait_pronto("envia_change");
    cycles(30);
    chk("envia_change_one_frame", ocupado, 0);

    // Randomized idle updates against the change/envia rule.
    for (int it = 0; it < 12; it++) begin
      logic [1:0] a_old, p_old;
      a_old       = andar_atual;
      p_old       = prox_parada;
      andar_atual = 2'($urandom_range(0, 3));
      prox_parada = 2'($urandom_range(0, 3));
      sobe        = 1'($urandom_range(0, 1));
      tem_destino = 1'($urandom_range(0, 1));
      eh_origem   = 1'($urandom_range(0, 1));
      do_envia    = ($urandom_range(0, 3) == 0);
      expect_frame = do_envia || (andar_atual != a_old) || (prox_parada != p_old);
      if (expect_frame) push_frame();
      envia = do_envia;
      cycles(1);
      envia = 1'b0;
      if (expect_frame) begin
        wait_pronto("rand_frame");
        cycles(3);
      end else begin
        cycles(20);
        chk("rand_no_frame", ocupado, 0);
      end
    end

    // Reset in the middle of byte1 data bits abandons the frame.
    push_frame();
    pulse_envia();
    n = 0;
    while (TX != 1'b0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    cycles(100);
    chk("midframe_estado", db_estado, 4'(DADOS));
    reset = 1'b0;
    cycles(1);
    chk("midrst_tx", TX, 1);
    chk("midrst_ocupado", ocupado, 0);
    chk("midrst_pronto", pronto, 0);
    chk("midrst_estado", db_estado, 4'(OCIOSO));
    exp_q.delete();
    frames_exp--;
    cycles(2);
    andar_atual = 2'($urandom_range(0, 3));
    prox_parada = 2'($urandom_range(0, 3));
    push_frame();
    reset = 1'b1;
    wait_pronto("after_reset_frame");
    cycles(5);

    chk("frames_total", frames_seen, frames_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
